// File: rtl/pcs_tx_block_scheduler.sv
// pcs_tx_block_scheduler
// Feeds the 10GBASE-R TX scrambler with a continuous stream of 66-bit blocks.
// Encoder blocks pass through when present, idle blocks fill the gaps, blocks
// with an illegal sync header are replaced by an error block, and one slot in
// every PAUSE_PERIOD is left empty for the downstream 64/66 gearbox.
//
// Ports:
//   tx_clk, tx_rst          clock and synchronous active-high reset
//   enable                  1 = scheduling active
//   enc_data/valid/ready    block input from the 64b/66b encoder
//   out_data/valid/ready    registered block output to the scrambler
//   idle_cnt, hdr_err_cnt   saturating RUN-idle and header-error counters
//   state_o                 0 OFF, 1 WARMUP, 2 RUN
//
// state  | meaning
// OFF    | disabled, no loads, slot counter held at 0
// WARMUP | emitting STARTUP_IDLES idle blocks, encoder not yet served
// RUN    | encoder blocks forwarded, idles inserted when encoder is empty
module pcs_tx_block_scheduler #(
  parameter int DATA_WIDTH    = 66,
  parameter int PAUSE_PERIOD  = 33,
  parameter int STARTUP_IDLES = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_BLOCK  = 66'h2_0000_0000_0000_001E,
  parameter logic [DATA_WIDTH-1:0] ERROR_BLOCK = 66'h2_3C78_F1E3_C78F_1E1E
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] enc_data,
  input  logic                  enc_valid,
  output logic                  enc_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           idle_cnt,
  output logic [15:0]           hdr_err_cnt,
  output logic [1:0]            state_o
);

  localparam int SW = $clog2(PAUSE_PERIOD);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                state;
  logic [SW-1:0]         slot_cnt;
  logic [7:0]            warm_cnt;
  logic                  pause_slot;
  logic                  load_en;
  logic                  hdr_ok;
  logic [DATA_WIDTH-1:0] sel_block;
  logic                  sel_idle;
  logic                  sel_err;

  assign pause_slot = (state != OFF) && (slot_cnt == SW'(PAUSE_PERIOD - 1));
  assign load_en    = (state != OFF) && !pause_slot && (!out_valid || out_ready);
  assign enc_ready  = (state == RUN) && load_en;
  assign state_o    = state;

  // Only 01 and 10 are legal sync headers.
  assign hdr_ok = enc_data[DATA_WIDTH-1] ^ enc_data[DATA_WIDTH-2];

  always_comb begin
    sel_block = IDLE_BLOCK;
    sel_idle  = 1'b0;
    sel_err   = 1'b0;
    if (state == RUN) begin
      if (enc_valid) begin
        if (hdr_ok) begin
          sel_block = enc_data;
        end else begin
          sel_block = ERROR_BLOCK;
          sel_err   = 1'b1;
        end
      end else begin
        sel_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state       <= OFF;
      slot_cnt    <= '0;
      warm_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      idle_cnt    <= '0;
      hdr_err_cnt <= '0;
    end else begin
      if (state == OFF || slot_cnt == SW'(PAUSE_PERIOD - 1)) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end

      if (load_en) begin
        out_data  <= sel_block;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_en && sel_idle && idle_cnt != 16'hFFFF) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (load_en && sel_err && hdr_err_cnt != 16'hFFFF) begin
        hdr_err_cnt <= hdr_err_cnt + 16'd1;
      end

      // Dropping enable wins over finishing warmup.
      case (state)
        OFF: begin
          if (enable) begin
            state    <= WARMUP;
            warm_cnt <= 8'(STARTUP_IDLES);
          end
        end
        WARMUP: begin
          if (!enable) begin
            state <= OFF;
          end else if (load_en) begin
            warm_cnt <= warm_cnt - 8'd1;
            if (warm_cnt == 8'd1) state <= RUN;
          end
        end
        RUN: begin
          if (!enable) state <= OFF;
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_block_scheduler.sv
module tb_pcs_tx_block_scheduler;

  localparam logic [65:0] IDLE = 66'h2_0000_0000_0000_001E;
  localparam logic [65:0] ERR  = 66'h2_3C78_F1E3_C78F_1E1E;
  localparam int PERIOD = 33;
  localparam int WARM   = 4;

  logic        tx_clk;
  logic        tx_rst;
  logic        enable;
  logic [65:0] enc_data;
  logic        enc_valid;
  logic        enc_ready;
  logic [65:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] idle_cnt;
  logic [15:0] hdr_err_cnt;
  logic [1:0]  state_o;

  pcs_tx_block_scheduler dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .enable(enable),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .idle_cnt(idle_cnt), .hdr_err_cnt(hdr_err_cnt), .state_o(state_o)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-stream view. m_age counts cycles since the
  // scheduler was switched on; every PERIOD-th cycle is the empty slot.
  logic        chk_en = 1'b0;
  logic        m_on = 1'b0, m_run = 1'b0, m_valid = 1'b0, m_acc = 1'b0;
  int          m_age = 0, m_warm = 0;
  logic [65:0] m_data = '0;
  int          m_idle = 0, m_herr = 0;
  logic [65:0] exp_q[$];
  logic        ld;

  // Scoreboard monitor: every handshake with the scrambler pops one block.
  always @(negedge tx_clk) begin
    if (chk_en && !tx_rst && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_block", out_data, 66'hx);
      end else begin
        chk("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  int          mode = 0;
  logic [65:0] src_q[$];

  // Encoder: a block offered is held until it is taken.
  task automatic next_enc();
    logic [1:0] h;
    if (enc_valid && !m_acc) return;
    enc_valid = 1'b0;
    enc_data  = '0;
    case (mode)
      1: if (src_q.size() > 0) begin
           enc_data  = src_q.pop_front();
           enc_valid = 1'b1;
         end
      2: if ($urandom_range(9) < 7) begin
           h = 2'($urandom_range(3));
           if ($urandom_range(3) != 0) h = 2'b01;
           enc_data  = {h, 32'($urandom), 32'($urandom)};
           enc_valid = 1'b1;
         end
      default: ;
    endcase
  endtask

  task automatic cycle();
    logic [65:0] blk;
    logic        pause;
    next_enc();
    @(negedge tx_clk);
    pause = m_on && (m_age % PERIOD == PERIOD - 1);
    ld    = m_on && !pause && (!m_valid || out_ready);
    if (chk_en) begin
      chk("state_o", 66'(state_o), 66'(m_run ? 2 : (m_on ? 1 : 0)));
      chk("out_valid", 66'(out_valid), 66'(m_valid));
      chk("out_data", out_data, m_data);
      chk("enc_ready", 66'(enc_ready), 66'(m_run && ld));
      chk("idle_cnt", 66'(idle_cnt), 66'(m_idle));
      chk("hdr_err_cnt", 66'(hdr_err_cnt), 66'(m_herr));
    end
    #1;
    if (tx_rst) begin
      m_on = 0; m_run = 0; m_valid = 0; m_data = '0; m_acc = 0;
      m_idle = 0; m_herr = 0; m_age = 0;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      m_acc = 1'b0;
      if (ld) begin
        if (!m_run) begin
          blk = IDLE;
          m_warm--;
          if (m_warm == 0) m_run = 1;
        end else if (enc_valid) begin
          m_acc = 1'b1;
          if (enc_data[65:64] == 2'b01 || enc_data[65:64] == 2'b10) begin
            blk = enc_data;
          end else begin
            blk = ERR;
            if (m_herr < 16'hFFFF) m_herr++;
          end
        end else begin
          blk = IDLE;
          if (m_idle < 16'hFFFF) m_idle++;
        end
        m_data = blk; m_valid = 1; exp_q.push_back(blk);
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (!enable) begin
        m_on = 0; m_run = 0;
      end else if (!m_on) begin
        m_on = 1; m_run = 0; m_warm = WARM; m_age = 0;
      end else begin
        m_age++;
      end
    end
    @(posedge tx_clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int guard;
    tx_rst = 1; enable = 0; out_ready = 0; enc_valid = 0; enc_data = '0;
    cycles(3);

    // Warmup then RUN idles.
    tx_rst = 0; enable = 1; out_ready = 1; mode = 0;
    cycles(40);

    // Streaming with header 01 and incrementing payload.
    for (int i = 0; i < 120; i++) src_q.push_back({2'b01, 64'(i + 1)});
    mode = 1;
    cycles(130);

    // Illegal headers then a legal 10 block.
    src_q.push_back({2'b00, 64'hDEAD_0000_0000_0001});
    src_q.push_back({2'b11, 64'hDEAD_0000_0000_0002});
    src_q.push_back({2'b10, 64'h1234_5678_9ABC_DEF0});
    cycles(8);
    chk("hdr_err_after_pair", 66'(hdr_err_cnt), 66'd2);

    // Output stall for 10 cycles while streaming.
    for (int i = 0; i < 40; i++) src_q.push_back({2'b10, 32'($urandom), 32'($urandom)});
    cycles(3);
    out_ready = 0;
    cycles(10);
    out_ready = 1;
    cycles(20);

    // Random traffic and backpressure.
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end

    // Drop enable while a block is held.
    mode = 1;
    for (int i = 0; i < 10; i++) src_q.push_back({2'b01, 32'($urandom), 32'($urandom)});
    out_ready = 0;
    guard = 0;
    while (!m_valid && guard < 50) begin cycle(); guard++; end
    if (!m_valid) chk("held_block_timeout", 66'd0, 66'd1);
    enable = 0;
    cycles(5);
    out_ready = 1;
    cycles(3);
    chk("state_off_after_drain", 66'(state_o), 66'd0);
    enable = 1;
    cycles(30);

    // Long idle run to saturate idle_cnt, then five more loads.
    mode = 0; out_ready = 1;
    guard = 0;
    while (m_idle < 16'hFFFF && guard < 80000) begin cycle(); guard++; end
    if (m_idle < 16'hFFFF) chk("idle_sat_timeout", 66'd0, 66'd1);
    cycles(6);
    chk("idle_cnt_saturated", 66'(idle_cnt), 66'hFFFF);

    // Reset in the middle of traffic.
    mode = 2;
    cycles(15);
    tx_rst = 1;
    cycle();
    tx_rst = 0;
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_out_data", out_data, 66'd0);
    chk("rst_idle_cnt", 66'(idle_cnt), 66'd0);
    chk("rst_state", 66'(state_o), 66'd0);
    cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
